// File: rtl/pid_autotuner_zn.sv
// rtl/pid_autotuner_zn.sv - Ziegler-Nichols gain-sweep autotuner for the BLDC speed PID loop
// Sweeps a probe gain until error oscillation stops decaying, then derives Kp/Ki/Kd.
module pid_autotuner_zn #(
  parameter int DATA_WIDTH = 16,
  parameter int K_WIDTH    = 8,
  parameter int KD_WIDTH   = 7,
  parameter int AVG_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_en,
  input  logic                         start,
  input  logic [2:0]                   pid_select,
  input  logic signed [DATA_WIDTH-1:0] error,
  output logic [K_WIDTH-1:0]           kp_probe,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [K_WIDTH-1:0]           ku,
  output logic [DATA_WIDTH-1:0]        pu,
  output logic [K_WIDTH-1:0]           kp,
  output logic [K_WIDTH-1:0]           ki,
  output logic [KD_WIDTH-1:0]          kd
);

  localparam int DW2     = 2 * DATA_WIDTH;
  localparam int AVG_LOG = $clog2(AVG_CYCLES);
  localparam int CW      = $clog2(AVG_CYCLES + 1);
  localparam int SW      = DATA_WIDTH + AVG_LOG;
  localparam int DCW     = $clog2(DW2);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [K_WIDTH-1:0]    PROBE_MAX = '1;
  localparam logic [KD_WIDTH-1:0]   KD_MAX    = '1;
  localparam logic [2:0] SEL_P = 3'b100, SEL_PI = 3'b110, SEL_PID = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_COMPUTE_KP, S_COMPUTE_KI, S_COMPUTE_KD, S_DONE, S_FAIL
  } state_t;
  typedef enum logic [1:0] {D_LOAD, D_RUN, D_WB} dphase_t;

  state_t                       state;
  state_t                       next_compute;
  dphase_t                      dphase;
  logic [2:0]                   sel;
  logic                         prev_neg;
  logic [DATA_WIDTH-1:0]        cnt;
  logic signed [DATA_WIDTH-1:0] max_e, min_e;
  logic [DATA_WIDTH:0]          first_amp;
  logic [CW-1:0]                ncross;
  logic [SW-1:0]                sum;
  logic [DW2-1:0]               div_rem, div_quo, div_den;
  logic [DCW-1:0]               div_cnt;

  logic                         rising, last_period, measuring, do_accept, do_step, valid_sel;
  logic [DATA_WIDTH-1:0]        cnt_inc;
  logic signed [DATA_WIDTH-1:0] max_n, min_n;
  logic [DATA_WIDTH:0]          amp;
  logic [CW-1:0]                ncross_n;
  logic [SW-1:0]                sum_n;
  logic [DW2-1:0]               ku_w, pu_w, div_num, div_dvs, rem_nx, quo_nx;
  logic [DW2:0]                 rem_sh;
  logic                         rem_ge, div_zero, commit;
  logic [K_WIDTH-1:0]           k_val;
  logic [KD_WIDTH-1:0]          kd_val;

  assign rising      = sample_en && !error[DATA_WIDTH-1] && prev_neg;
  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign max_n       = (error > max_e) ? error : max_e;
  assign min_n       = (error < min_e) ? error : min_e;
  assign amp         = {max_n[DATA_WIDTH-1], max_n} - {min_n[DATA_WIDTH-1], min_n};
  assign ncross_n    = ncross + 1'b1;
  assign sum_n       = sum + SW'(cnt_inc);
  assign last_period = rising && (ncross_n == CW'(AVG_CYCLES));
  assign measuring   = (state == S_SETTLE) || (state == S_MEASURE);
  assign do_accept   = (state == S_MEASURE) && last_period && (amp >= first_amp);
  // A crossing always takes precedence over a coincident timeout.
  assign do_step     = ((state == S_MEASURE) && last_period && (amp < first_amp)) ||
                       (measuring && sample_en && !rising && (cnt_inc == TIMEOUT));
  assign valid_sel   = (sel == SEL_P) || (sel == SEL_PI) || (sel == SEL_PID);

  assign ku_w   = DW2'(ku);
  assign pu_w   = DW2'(pu);
  assign rem_sh = {div_rem, div_quo[DW2-1]};
  assign rem_ge = rem_sh >= {1'b0, div_den};
  assign rem_nx = rem_ge ? DW2'(rem_sh - {1'b0, div_den}) : rem_sh[DW2-1:0];
  assign quo_nx = {div_quo[DW2-2:0], rem_ge};
  assign commit = (dphase == D_WB) || ((dphase == D_LOAD) && div_zero);
  assign k_val  = (dphase != D_WB) ? '0 :
                  (|div_quo[DW2-1:K_WIDTH]) ? PROBE_MAX : div_quo[K_WIDTH-1:0];
  assign kd_val = (dphase != D_WB) ? '0 :
                  (|div_quo[DW2-1:KD_WIDTH]) ? KD_MAX : div_quo[KD_WIDTH-1:0];

  always_comb begin
    div_num      = '0;
    div_dvs      = '0;
    div_zero     = 1'b1;
    next_compute = S_DONE;
    case (state)
      S_COMPUTE_KP: begin
        next_compute = S_COMPUTE_KI;
        div_zero     = 1'b0;
        case (sel)
          SEL_P:   begin div_num = ku_w;              div_dvs = DW2'(2);   end
          SEL_PI:  begin div_num = DW2'(45) * ku_w;   div_dvs = DW2'(100); end
          default: begin div_num = DW2'(6) * ku_w;    div_dvs = DW2'(10);  end
        endcase
      end
      S_COMPUTE_KI: begin
        next_compute = S_COMPUTE_KD;
        if (sel == SEL_PI) begin
          div_zero = 1'b0;
          div_num  = DW2'(54) * ku_w;
          div_dvs  = DW2'(100) * pu_w;
        end else if (sel == SEL_PID) begin
          div_zero = 1'b0;
          div_num  = DW2'(12) * ku_w;
          div_dvs  = DW2'(10) * pu_w;
        end
      end
      S_COMPUTE_KD: begin
        if (sel == SEL_PID) begin
          div_zero = 1'b0;
          div_num  = DW2'(3) * ku_w * pu_w;
          div_dvs  = DW2'(40);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      dphase    <= D_LOAD;
      sel       <= '0;
      prev_neg  <= 1'b0;
      cnt       <= '0;
      max_e     <= '0;
      min_e     <= '0;
      first_amp <= '0;
      ncross    <= '0;
      sum       <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      div_den   <= '0;
      div_cnt   <= '0;
      kp_probe  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      ku        <= '0;
      pu        <= '0;
      kp        <= '0;
      ki        <= '0;
      kd        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel      <= pid_select;
            kp_probe <= K_WIDTH'(1);
            busy     <= 1'b1;
            done     <= 1'b0;
            fail     <= 1'b0;
            prev_neg <= 1'b0;
            cnt      <= '0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE, S_MEASURE: begin
          if (sample_en) begin
            prev_neg <= error[DATA_WIDTH-1];
            if (do_accept) begin
              ku <= kp_probe;
              pu <= DATA_WIDTH'(sum_n >> AVG_LOG);
              if (valid_sel) begin
                state  <= S_COMPUTE_KP;
                dphase <= D_LOAD;
              end else begin
                kp    <= '0;
                ki    <= '0;
                kd    <= '0;
                state <= S_DONE;
              end
            end else if (do_step) begin
              cnt <= '0;
              if (kp_probe == PROBE_MAX) begin
                state <= S_FAIL;
              end else begin
                kp_probe <= kp_probe + 1'b1;
                state    <= S_SETTLE;
              end
            end else if (rising) begin
              cnt   <= '0;
              max_e <= error;
              min_e <= error;
              state <= S_MEASURE;
              if (state == S_SETTLE) begin
                ncross <= '0;
                sum    <= '0;
              end else begin
                ncross <= ncross_n;
                sum    <= sum_n;
                if (ncross == '0) first_amp <= amp;
              end
            end else begin
              cnt   <= cnt_inc;
              max_e <= max_n;
              min_e <= min_n;
            end
          end
        end
        S_COMPUTE_KP, S_COMPUTE_KI, S_COMPUTE_KD: begin
          if (commit) begin
            case (state)
              S_COMPUTE_KP: kp <= k_val;
              S_COMPUTE_KI: ki <= k_val;
              default:      kd <= kd_val;
            endcase
            state  <= next_compute;
            dphase <= D_LOAD;
          end else if (dphase == D_LOAD) begin
            // Dividend is parked in the quotient register and shifted out MSB first.
            div_rem <= '0;
            div_quo <= div_num;
            div_den <= div_dvs;
            div_cnt <= DCW'(DW2 - 1);
            dphase  <= D_RUN;
          end else begin
            div_rem <= rem_nx;
            div_quo <= quo_nx;
            div_cnt <= div_cnt - 1'b1;
            if (div_cnt == '0) dphase <= D_WB;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          kp_probe <= '0;
          state    <= S_IDLE;
        end
        S_FAIL: begin
          fail     <= 1'b1;
          busy     <= 1'b0;
          kp_probe <= '0;
          ku       <= '0;
          pu       <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_autotuner_zn.sv
// tb/tb_pid_autotuner_zn.sv - scoreboard bench for pid_autotuner_zn
// Two instances: u_main (long timeout) for tuning runs, u_to (TIMEOUT=64) for the failure sweep.
module tb_pid_autotuner_zn;
  localparam int DW = 16, KW = 8, KDW = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, sen_a = 1'b0, start_b = 1'b0, sen_b = 1'b0;
  logic [2:0] sel_a = '0, sel_b = '0;
  logic signed [DW-1:0] err_a = '0, err_b = '0;
  logic [KW-1:0] probe_a, ku_a, kp_a, ki_a, probe_b, ku_b, kp_b, ki_b;
  logic [DW-1:0] pu_a, pu_b;
  logic [KDW-1:0] kd_a, kd_b;
  logic busy_a, done_a, fail_a, busy_b, done_b, fail_b;

  pid_autotuner_zn #(.DATA_WIDTH(DW), .K_WIDTH(KW), .KD_WIDTH(KDW), .AVG_CYCLES(4),
                     .TIMEOUT(16'd1500)) u_main (
    .clk(clk), .reset_n(reset_n), .sample_en(sen_a), .start(start_a), .pid_select(sel_a),
    .error(err_a), .kp_probe(probe_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .ku(ku_a), .pu(pu_a), .kp(kp_a), .ki(ki_a), .kd(kd_a));

  pid_autotuner_zn #(.DATA_WIDTH(DW), .K_WIDTH(KW), .KD_WIDTH(KDW), .AVG_CYCLES(4),
                     .TIMEOUT(16'd64)) u_to (
    .clk(clk), .reset_n(reset_n), .sample_en(sen_b), .start(start_b), .pid_select(sel_b),
    .error(err_b), .kp_probe(probe_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .ku(ku_b), .pu(pu_b), .kp(kp_b), .ki(ki_b), .kd(kd_b));

  typedef struct {
    bit is_fail;
    int ku, pu, kp, ki, kd;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_checks = 0;
  int n_errors = 0;
  logic busy_a_q = 1'b0, busy_b_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ziegler-Nichols tables with integer truncation and output saturation.
  function automatic exp_t model(input int sel, input int ku, input int pu);
    exp_t e;
    e.is_fail = 1'b0; e.ku = ku; e.pu = pu; e.kp = 0; e.ki = 0; e.kd = 0;
    case (sel)
      4: e.kp = ku / 2;
      6: begin e.kp = 45 * ku / 100; e.ki = 54 * ku / (100 * pu); end
      7: begin e.kp = 6 * ku / 10; e.ki = 12 * ku / (10 * pu); e.kd = 3 * ku * pu / 40; end
      default: ;
    endcase
    if (e.kp > 255) e.kp = 255;
    if (e.ki > 255) e.ki = 255;
    if (e.kd > 127) e.kd = 127;
    return e;
  endfunction

  // Square wave, negative first half; decaying variant shrinks each period.
  function automatic int wave(input int n, input int p, input int a, input bit decay);
    int k, amp;
    k = n / p;
    amp = decay ? (((100 - 15 * k) < 10) ? 10 : 100 - 15 * k) : a;
    return ((n % p) < p / 2) ? -amp : amp;
  endfunction

  task automatic compare_out(input string tag, input exp_t e, input logic [31:0] probe,
                             input logic [31:0] ku, pu, kp, ki, kd, input logic dn, fl);
    check({tag, "_done"}, dn, e.is_fail ? 0 : 1);
    check({tag, "_fail"}, fl, e.is_fail ? 1 : 0);
    check({tag, "_probe"}, probe, 0);
    check({tag, "_ku"}, ku, e.ku);
    check({tag, "_pu"}, pu, e.pu);
    if (!e.is_fail) begin
      check({tag, "_kp"}, kp, e.kp);
      check({tag, "_ki"}, ki, e.ki);
      check({tag, "_kd"}, kd, e.kd);
    end
  endtask

  task automatic check_zero(input string tag, input logic [31:0] probe, busy, done, fail,
                            input logic [31:0] ku, pu, kp, ki, kd);
    check({tag, "_probe"}, probe, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_ku"}, ku, 0);
    check({tag, "_pu"}, pu, 0);
    check({tag, "_kp"}, kp, 0);
    check({tag, "_ki"}, ki, 0);
    check({tag, "_kd"}, kd, 0);
  endtask

  always @(negedge clk) begin
    if (busy_a_q && !busy_a && (done_a || fail_a)) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL main_unexpected: result with empty scoreboard");
      end else begin
        compare_out("main", q_a.pop_front(), probe_a, ku_a, pu_a, kp_a, ki_a, kd_a, done_a, fail_a);
      end
    end
    busy_a_q <= busy_a;
  end

  always @(negedge clk) begin
    if (busy_b_q && !busy_b && (done_b || fail_b)) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL to_unexpected: result with empty scoreboard");
      end else begin
        compare_out("to", q_b.pop_front(), probe_b, ku_b, pu_b, kp_b, ki_b, kd_b, done_b, fail_b);
      end
    end
    busy_b_q <= busy_b;
  end

  task automatic run_a(input logic [2:0] sel, input int target, input int period, input int amp,
                       input bit gaps, input bit abort);
    int n, last, cyc;
    bit stop;
    if (!abort) q_a.push_back(model(int'(sel), target, period));
    @(posedge clk); #1;
    sel_a = sel; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    sel_a = 3'($urandom);
    check("start_busy", busy_a, 1);
    check("start_probe", probe_a, 1);
    n = 0; last = -1; cyc = 0; stop = 1'b0;
    while (!stop) begin
      if (int'(probe_a) != last) begin
        n = 0;
        last = int'(probe_a);
      end
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        sen_a = 1'b0;
      end else begin
        sen_a = 1'b1;
        err_a = DW'(wave(n, (last == target) ? period : 8, amp, last != target));
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (!busy_a || cyc >= 60000 || (abort && ku_a != 0)) stop = 1'b1;
    end
    sen_a = 1'b0;
    if (cyc >= 60000) begin
      n_checks++; n_errors++;
      $display("FAIL main_budget: busy=%0d after %0d cycles, required 0", busy_a, cyc);
    end
    if (!abort) repeat (2) @(posedge clk);
  endtask

  task automatic run_timeout();
    exp_t e;
    int cyc, lastb, maxp, bad;
    e = model(0, 0, 1);
    e.is_fail = 1'b1; e.pu = 0;
    q_b.push_back(e);
    @(posedge clk); #1;
    sel_b = 3'b111; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    check("to_start_busy", busy_b, 1);
    check("to_start_probe", probe_b, 1);
    cyc = 0; lastb = 1; maxp = 1; bad = 0;
    while (busy_b && cyc < 20000) begin
      sen_b = 1'b1;
      err_b = 16'sd50;
      start_b = (cyc == 1000);
      @(posedge clk); #1;
      cyc++;
      if (int'(probe_b) != lastb) begin
        if (probe_b != 0 && int'(probe_b) != lastb + 1) bad++;
        lastb = int'(probe_b);
        if (lastb > maxp) maxp = lastb;
      end
    end
    sen_b = 1'b0; start_b = 1'b0;
    if (cyc >= 20000) begin
      n_checks++; n_errors++;
      $display("FAIL to_budget: busy=%0d after %0d cycles, required 0", busy_b, cyc);
    end
    check("to_max_probe", maxp, 255);
    check("to_probe_steps", bad, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int pick, tgt, per, amp;
    logic [2:0] s;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_a", probe_a, busy_a, done_a, fail_a, ku_a, pu_a, kp_a, ki_a, kd_a);
    check_zero("rst_b", probe_b, busy_b, done_b, fail_b, ku_b, pu_b, kp_b, ki_b, kd_b);
    reset_n = 1'b1;

    run_timeout();

    // PID run interrupted by reset while the Ki divide is in flight.
    run_a(3'b111, 20, 16, 100, 1'b1, 1'b1);
    repeat (40) @(posedge clk);
    #3;
    check("pre_reset_kp", kp_a, 12);
    reset_n = 1'b0;
    #1;
    check_zero("abort_a", probe_a, busy_a, done_a, fail_a, ku_a, pu_a, kp_a, ki_a, kd_a);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_a(3'b111, 20, 16, 100, 1'b1, 1'b0);
    run_a(3'b100, 5, 20, 100, 1'b1, 1'b0);
    run_a(3'b110, 50, 10, 100, 1'b1, 1'b0);
    run_a(3'b111, 255, 1000, 300, 1'b0, 1'b0);
    run_a(3'b010, 3, 12, 80, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pick = $urandom_range(0, 3);
      s = (pick == 0) ? 3'b100 : (pick == 1) ? 3'b110 : (pick == 2) ? 3'b111 : 3'($urandom);
      tgt = $urandom_range(1, 30);
      per = 2 * $urandom_range(2, 30);
      amp = $urandom_range(1, 3000);
      run_a(s, tgt, per, amp, 1'b1, 1'b0);
    end

    repeat (4) @(posedge clk);
    check("sb_drained", q_a.size() + q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pid_autotuner_zn.md
# pid_autotuner_zn

Parametrised Ziegler–Nichols relay-free autotuner for the BLDC speed PID loop; successor to the single-shot tuner. Sweeps a probe proportional gain, detects sustained oscillation of the loop error over several periods, latches ultimate gain Ku and averaged period Pu, then computes Kp/Ki/Kd for P, PI or PID mode with an internal sequential divider. It sits between the speed-error path and the PID core, driving the probe gain during tuning and the final coefficients afterwards.

## Interface
- DATA_WIDTH, 16, error / period width; period counter saturates at 2^DATA_WIDTH-1
- K_WIDTH, 8, width of kp, ki, probe and Ku; must satisfy K_WIDTH <= DATA_WIDTH-2
- KD_WIDTH, 7, width of kd
- AVG_CYCLES, 4, oscillation periods averaged per probe step; power of two, >= 2
- TIMEOUT, 16'hFFFF, samples without a rising zero crossing before the probe is declared non-oscillating
- clk  in  1  single system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_en  in  1  one-cycle strobe marking a valid `error` sample
- start  in  1  one-cycle pulse starting a tuning run; ignored while busy
- pid_select  in  3  100=P, 110=PI, 111=PID, else invalid; sampled on start
- error  in  DATA_WIDTH signed  setpoint minus measured speed
- kp_probe  out  K_WIDTH  gain the PID core applies during the search
- busy  out  1  run in progress
- done  out  1  sticky success flag, cleared by the next start
- fail  out  1  sticky failure flag, cleared by the next start
- ku, pu  out  K_WIDTH / DATA_WIDTH  latched ultimate gain and averaged period in samples
- kp, ki, kd  out  K_WIDTH / K_WIDTH / KD_WIDTH  tuned coefficients

## Operation
- Reset values: kp_probe, ku, pu, kp, ki, kd = 0; busy, done, fail = 0. FSM goes to IDLE.
- States: IDLE, SETTLE, MEASURE, COMPUTE_KP, COMPUTE_KI, COMPUTE_KD, DONE, FAIL.
- IDLE: on start, latch pid_select, set kp_probe=1, busy=1, clear done/fail, clear the crossing history, go to SETTLE.
- Rising crossing: a sampled `error` that is >= 0 when the previous sample was < 0. The history register is updated only on sample_en.
- SETTLE: wait for the first rising crossing, reset the period counter and the max/min trackers, then go to MEASURE.
- MEASURE, on each sample: period_cnt += 1 (saturating), track max/min of error. On each rising crossing, record the period, amplitude = max-min, and the crossing count, then restart the counter and trackers.
- After AVG_CYCLES periods:
  - If the last amplitude >= the first amplitude (non-decaying): ku=kp_probe, pu = sum of periods >> log2(AVG_CYCLES), go to COMPUTE_KP.
  - Otherwise kp_probe += 1 and go to SETTLE.
- If period_cnt reaches TIMEOUT: kp_probe += 1 and go to SETTLE.
- In both cases, if kp_probe is already 2^K_WIDTH-1, go to FAIL instead.
- Compute formulas, all integer and truncating:
  - P: kp = ku>>1; ki = kd = 0.
  - PI: kp = 45·ku/100; ki = 54·ku/(100·pu); kd = 0.
  - PID: kp = 6·ku/10; ki = 12·ku/(10·pu); kd = 3·ku·pu/40.
- Invalid select: kp = ki = kd = 0, go straight to DONE.
- Divider: one shared restoring shift-subtract divider, 2·DATA_WIDTH bits, one quotient bit per clk. Each quotient saturates to its output width. States with a zero result skip the divide.
- DONE: done=1, busy=0, kp_probe=0. FAIL: fail=1, busy=0, kp_probe=0, ku=pu=0. Both return to IDLE immediately and hold their flags.
- sample_en is ignored outside SETTLE and MEASURE. start is ignored unless busy=0.
- reset_n low in any state returns all outputs to their reset values on that edge; no partial results are retained.

## Timing
- start to busy=1 and kp_probe=1: next clk edge.
- Crossing detection acts on the sample_en cycle itself. kp_probe changes one clk after the deciding sample.
- Each divide takes 2·DATA_WIDTH+2 clk including load and writeback. The whole compute phase is ≤ 3·(2·DATA_WIDTH+2) clk.
- kp/ki/kd update on the writeback cycle of their divide. done rises one clk after the last writeback.
- If a crossing and TIMEOUT coincide, the crossing wins.

## Test plan
- P mode, AVG_CYCLES=4: bench drives a ±100 error wave of period 20 samples with decaying amplitude while kp_probe<5 and constant amplitude at 5. Expect ku=5, pu=20, kp=2, ki=0, kd=0, done=1.
- PID mode with constant oscillation at kp_probe=20, period 16. Expect kp=12, ki=1, kd=24.
- PI mode with oscillation at kp_probe=50, period 10. Expect kp=22, ki=2, kd=0.
- TIMEOUT=64, error held at +50, PID mode. Expect kp_probe to step 1→255, then fail=1, done=0, busy=0, ku=0.
- PID saturation: ku=255, pu=1000. Expect kp=153, ki=0, kd=127 (saturated from 19125).
- reset_n pulsed low during COMPUTE_KI. Expect all outputs 0 asynchronously. A later start restarts at kp_probe=1 and reproduces the expected results.
